seq_multiplier: RTL and testbench

- Iterative shift-and-add unsigned multiplier.
- Sits directly upstream of the 16-bit datapath register.
- `product` drives the register's `din`; the one-cycle `done` pulse drives the register's `load`.
- Operands are captured on `start`. One multiplier bit is processed per clock. The result is held until the next operation completes.

---
 rtl/seq_multiplier.sv | 95 +++++++++
 tb/tb_seq_multiplier.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional early termination on exhausted multiplier: define SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d, product_q;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q;
  logic               busy_q, done_q, last_d;

  // Datapath step taken in RUN: conditional add, then the shifted multiplier.
  always_comb begin
    acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mplier_d = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    last_d   = (count_q == CW'(1)) || (mplier_d == '0);
`else
    last_d   = (count_q == CW'(1));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= RUN;
`ifdef SEQ_MULT_EARLY_TERM_EN
            if (b == '0) begin
              product_q <= '0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
`endif
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          count_q  <= count_q - CW'(1);
          if (last_d) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random operands
// against an arithmetic reference (product = a*b, latency from the bits of b).
module tb_seq_multiplier;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   a = '0, b = '0;
  logic               busy, done;
  logic [2*WIDTH-1:0] product;

  int errs = 0;
  int checks = 0;
  logic [2*WIDTH-1:0] last_prod = '0;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Edges after the accepting edge until done is observed high.
  function automatic int exp_lat(input logic [WIDTH-1:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
    if (bv == '0) return 0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (bv[i]) return i + 1;
    return 0;
`else
    return WIDTH;
`endif
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit intf);
    int k;
    bit stable;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    chk("busy_rise", 32'(busy), 32'd1);
    k = 0;
    stable = 1'b1;
    while (!done && k < WIDTH + 4) begin
      if (product !== last_prod) stable = 1'b0;
      @(posedge clk); #1;
      k++;
      if (intf && k == 3) begin start = 1'b1; a = 8'd9; b = 8'd9; end
      if (k == 4) start = 1'b0;
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'(exp_lat(bv)));
    chk("no_partial", 32'(stable), 32'd1);
    last_prod = 16'(av) * 16'(bv);
    chk("product", 32'(product), 32'(last_prod));
    @(posedge clk); #1;
    chk("done_single", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("product_hold", 32'(product), 32'(last_prod));
  endtask

  initial begin
    #2;
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_rst", 32'(busy), 32'd0);

    run_op(8'd12, 8'd10, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd0, 8'd200, 1'b0);
    run_op(8'd1, 8'd1, 1'b0);
    run_op(8'd3, 8'd4, 1'b1);
    run_op(8'd5, 8'd0, 1'b0);
    run_op(8'd3, 8'd2, 1'b0);
    run_op(8'd1, 8'd128, 1'b0);

    // Abort mid-run: reset between edges must clear outputs at once.
    @(negedge clk);
    a = 8'd100; b = 8'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    last_prod = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (WIDTH + 2) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_idle", 32'(busy), 32'd0);
    run_op(8'd7, 8'd6, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = (i % 5 == 0) ? WIDTH'(1 << $urandom_range(WIDTH - 1, 0)) : WIDTH'($urandom);
      run_op(ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
